// File: rtl/cu_condlogic.sv
// cu_condlogic: conditional-execution stage of the ARM single-cycle control unit.
// Holds the NZCV flag register, evaluates the condition field against it and
// gates the raw decoder strobes into committed PCSrc/RegWrite/MemWrite.
// Optional feature macro: CU_SQUASH_CNT_EN adds a saturating counter of valid
// instructions that failed their condition (SquashCount port, CNT_W bits).
module cu_condlogic #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InstrValid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
`ifdef CU_SQUASH_CNT_EN
    output logic [CNT_W-1:0] SquashCount,
`endif
    output logic [3:0]       Flags
);

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Counter width must be usable in either build
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("cu_condlogic: CNT_W must be at least 1");
    end

    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_pass_c;
    logic       cond_ex_c;

    assign flag_n = nz_q[1];
    assign flag_z = nz_q[0];
    assign flag_c = cv_q[1];
    assign flag_v = cv_q[0];

    // Condition evaluation against stored flags; bubbles never look at Cond so X cannot leak
    always_comb begin
        cond_pass_c = 1'b0;
        if (InstrValid) begin
            case (Cond)
                COND_EQ: cond_pass_c = flag_z;
                COND_NE: cond_pass_c = ~flag_z;
                COND_CS: cond_pass_c = flag_c;
                COND_CC: cond_pass_c = ~flag_c;
                COND_MI: cond_pass_c = flag_n;
                COND_PL: cond_pass_c = ~flag_n;
                COND_VS: cond_pass_c = flag_v;
                COND_VC: cond_pass_c = ~flag_v;
                COND_HI: cond_pass_c = flag_c & ~flag_z;
                COND_LS: cond_pass_c = ~flag_c | flag_z;
                COND_GE: cond_pass_c = ~(flag_n ^ flag_v);
                COND_LT: cond_pass_c = flag_n ^ flag_v;
                COND_GT: cond_pass_c = ~flag_z & ~(flag_n ^ flag_v);
                COND_LE: cond_pass_c = flag_z | (flag_n ^ flag_v);
                COND_AL: cond_pass_c = 1'b1;
                default: cond_pass_c = 1'b0;   // unconditional space never executes
            endcase
        end
    end

    assign cond_ex_c = InstrValid & cond_pass_c;

    // Committed strobes, zero latency from the decoder
    always_comb begin
        CondEx   = cond_ex_c;
        PCSrc    = PCS & cond_ex_c;
        RegWrite = RegW & cond_ex_c & ~NoWrite;
        MemWrite = MemW & cond_ex_c;
    end

    // Next flag state: each half updates only for a passing instruction that asks for it
    always_comb begin
        nz_d = nz_q;
        cv_d = cv_q;
        if (FlagW[1] && cond_ex_c) begin
            nz_d = ALUFlags[3:2];
        end
        if (FlagW[0] && cond_ex_c) begin
            cv_d = ALUFlags[1:0];
        end
    end

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            nz_q <= nz_d;
            cv_q <= cv_d;
        end
    end

    assign Flags = {nz_q, cv_q};

`ifdef CU_SQUASH_CNT_EN
    localparam logic [CNT_W-1:0] SQ_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] sq_q, sq_d;

    // Count valid instructions whose condition failed, saturating at all-ones
    always_comb begin
        sq_d = sq_q;
        if (InstrValid && !cond_pass_c && (sq_q != SQ_MAX)) begin
            sq_d = sq_q + CNT_W'(1);
        end
    end

    // Squash counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign SquashCount = sq_q;
`endif

endmodule

// File: tb/tb_cu_condlogic.sv
// Self-checking bench for cu_condlogic: a flag/condition model checked every
// cycle plus directed vectors with hand-computed expectations.
module tb_cu_condlogic;

    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             InstrValid;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW, NoWrite;
    logic             PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]       Flags;
`ifdef CU_SQUASH_CNT_EN
    logic [CNT_W-1:0] SquashCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cu_condlogic #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .InstrValid (InstrValid),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .CondEx     (CondEx),
`ifdef CU_SQUASH_CNT_EN
        .SquashCount(SquashCount),
`endif
        .Flags      (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [3:0] m_flags;
    int       m_sq;

    // Pairs of conditions share a predicate; the odd member is its negation
    function automatic bit m_pass(input logic [3:0] c, input bit [3:0] f);
        bit n, z, cy, v, b;
        int pair;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'd15) return 1'b0;
        if (c == 4'd14) return 1'b1;
        pair = int'(c) / 2;
        case (pair)
            0: b = z;
            1: b = cy;
            2: b = n;
            3: b = v;
            4: b = cy && !z;
            5: b = (n == v);
            default: b = !z && (n == v);
        endcase
        return (int'(c) % 2 == 1) ? !b : b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags = 4'b0000;
            m_sq    = 0;
        end else if (InstrValid) begin
            if (m_pass(Cond, m_flags)) begin
                if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
                if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
            end else if (m_sq < (1 << CNT_W) - 1) begin
                m_sq = m_sq + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        bit ex;
        ex = InstrValid && m_pass(Cond, m_flags);
        chk("model_CondEx",   32'(CondEx),   32'(ex));
        chk("model_PCSrc",    32'(PCSrc),    32'(ex && PCS));
        chk("model_RegWrite", 32'(RegWrite), 32'(ex && RegW && !NoWrite));
        chk("model_MemWrite", 32'(MemWrite), 32'(ex && MemW));
        chk("model_Flags",    32'(Flags),    32'(m_flags));
`ifdef CU_SQUASH_CNT_EN
        chk("model_SquashCount", 32'(SquashCount), 32'(m_sq));
`endif
    end

    // Apply one instruction just after a rising edge, return after the following falling edge
    task automatic step(input logic v, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic pcs, input logic rw,
                        input logic mw, input logic nw);
        @(posedge clk);
        #1;
        InstrValid = v; Cond = c; ALUFlags = af; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        InstrValid = 1'b0; Cond = 4'b0; ALUFlags = 4'b0; FlagW = 2'b0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("reset_Flags", 32'(Flags), 32'h0);

        // AL commits, EQ fails and NE passes against cleared flags
        step(1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0);
        chk("al_RegWrite", 32'(RegWrite), 32'h1);
        chk("al_Flags", 32'(Flags), 32'h0);
        step(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0);
        chk("eq_reset_RegWrite", 32'(RegWrite), 32'h0);
        chk("eq_reset_CondEx", 32'(CondEx), 32'h0);
        step(1, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0);
        chk("ne_reset_CondEx", 32'(CondEx), 32'h1);

        // SUBS sets Z; dependent BEQ sees it only on the next cycle
        step(1, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 0);
        chk("subs_PCSrc_t", 32'(PCSrc), 32'h0);
        chk("subs_Flags_t", 32'(Flags), 32'h0);
        step(1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
        chk("beq_Flags", 32'(Flags), 32'h4);
        chk("beq_PCSrc", 32'(PCSrc), 32'h1);

        // ADDSNE with Z=1 fails: no writes, no flag change
        step(1, 4'b0001, 4'b1001, 2'b11, 0, 1, 1, 0);
        chk("addsne_CondEx", 32'(CondEx), 32'h0);
        chk("addsne_MemWrite", 32'(MemWrite), 32'h0);
        chk("addsne_RegWrite", 32'(RegWrite), 32'h0);
        step(1, 4'b1110, 4'b0010, 2'b11, 0, 0, 0, 0);
        chk("addsne_Flags_hold", 32'(Flags), 32'h4);

        // Partial write: only N,Z change, C,V preserved
        step(1, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0);
        chk("partial_Flags_before", 32'(Flags), 32'h2);
        step(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
        chk("partial_Flags_after", 32'(Flags), 32'he);

        // CMP: no register write, flags still update
        step(1, 4'b1110, 4'b0011, 2'b11, 0, 1, 0, 1);
        chk("cmp_RegWrite", 32'(RegWrite), 32'h0);
        chk("cmp_CondEx", 32'(CondEx), 32'h1);

        // Bubble: outputs quiet, flags hold even with X on Cond
        step(0, 4'bxxxx, 4'b1111, 2'b11, 1, 1, 1, 0);
        chk("cmp_Flags", 32'(Flags), 32'h3);
        chk("bubble_CondEx", 32'(CondEx), 32'h0);
        chk("bubble_PCSrc", 32'(PCSrc), 32'h0);
        chk("bubble_RegWrite", 32'(RegWrite), 32'h0);
        chk("bubble_MemWrite", 32'(MemWrite), 32'h0);

        // Flags 0011 (C=1,V=1): HI pass, GE fail, LT pass, 1111 never
        step(1, 4'b1000, 4'b0000, 2'b00, 0, 0, 0, 0);
        chk("bubble_Flags_hold", 32'(Flags), 32'h3);
        chk("hi_CondEx", 32'(CondEx), 32'h1);
        step(1, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0);
        chk("ge_CondEx", 32'(CondEx), 32'h0);
        step(1, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0);
        chk("lt_CondEx", 32'(CondEx), 32'h1);
        step(1, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0);
        chk("nv_CondEx", 32'(CondEx), 32'h0);

        // Random traffic, checked against the model every cycle
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Mid-operation reset: flags clear at once, outputs re-evaluate against 0000
        step(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
        step(1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
        chk("pre_reset_Flags", 32'(Flags), 32'hf);
        chk("pre_reset_PCSrc", 32'(PCSrc), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midreset_Flags", 32'(Flags), 32'h0);
        chk("midreset_PCSrc", 32'(PCSrc), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

`ifdef CU_SQUASH_CNT_EN
        // Five failing instructions: 1,2,3,3,3 then immediate clear on reset
        step(1, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0);
            chk("squash_count", 32'(SquashCount), 32'((k < 3) ? k : 3));
        end
        rst_n = 1'b0;
        #1;
        chk("squash_reset", 32'(SquashCount), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
`endif

        step(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
        step(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cu_condlogic.md
# cu_condlogic

Conditional-execution stage of the ARM single-cycle control unit. It sits directly downstream of the main decoder and ALU decoder. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the stored flags. It then gates the decoder's raw PCS, RegW and MemW strobes into the committed PCSrc, RegWrite and MemWrite that drive the PC mux, register file and data memory.

## Interface
Parameters:
- CNT_W, default 16, width of the squashed-instruction counter (only used with CU_SQUASH_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- InstrValid  in  1  current instruction is real. 0 means a bubble or stall: no commits, no flag update.
- Cond  in  4  instruction bits [31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  in  2  from the ALU decoder. [1] writes N,Z; [0] writes C,V.
- PCS  in  1  raw PC-source request (branch, or write to R15).
- RegW  in  1  raw register write from the main decoder.
- MemW  in  1  raw memory write from the main decoder.
- NoWrite  in  1  compare-class op (CMP/CMN/TST/TEQ): suppresses RegWrite only.
- PCSrc  out  1  committed PC source.
- RegWrite  out  1  committed register write.
- MemWrite  out  1  committed memory write.
- CondEx  out  1  condition passed (qualified by InstrValid).
- Flags  out  4  stored {N,Z,C,V}.
- SquashCount  out  CNT_W  valid instructions that failed their condition (only with CU_SQUASH_CNT_EN).

## Operation
- Condition decode against the stored Flags, never against ALUFlags:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: 0. The unconditional space is unsupported and never executes.
- CondEx = InstrValid & condition_passed.
- PCSrc = PCS & CondEx.
- RegWrite = RegW & CondEx & !NoWrite.
- MemWrite = MemW & CondEx.
- Flag register:
  - At the rising edge, N,Z take ALUFlags[3:2] if FlagW[1] & CondEx.
  - C,V take ALUFlags[1:0] if FlagW[0] & CondEx.
  - Otherwise the halves hold independently.
- A failed-condition instruction never updates any flag, including its own.
- NoWrite does not block flag updates.

## Timing
- Reset (async assert, synchronous release on the next clk edge): Flags=4'b0000, SquashCount=0.
  - Combinational outputs follow from Flags=0. For example, Cond=EQ gives CondEx=0 and Cond=NE gives CondEx=1.
- PCSrc, RegWrite, MemWrite and CondEx are combinational, with zero latency from Cond, InstrValid and the raw strobes in the same cycle.
- Flag writes have one-cycle latency: an instruction in cycle t sees Flags written by the instruction in cycle t-1. There is no same-cycle bypass.
- InstrValid=0: all four committed outputs are 0, and Flags and SquashCount hold.
- Reset asserted mid-operation: Flags clear immediately, and committed outputs re-evaluate combinationally against 0000.
- X on Cond while InstrValid=0 must not propagate X to the committed outputs. Gate with InstrValid first.

## Configuration
- CU_SQUASH_CNT_EN defined:
  - SquashCount increments by 1 on each edge where InstrValid=1 and condition_passed=0.
  - It saturates at all-ones with no wrap.
  - It clears only on reset.
- CU_SQUASH_CNT_EN undefined:
  - The SquashCount port is absent and no counter flops are synthesized.
  - All other behaviour is identical.

## Test plan
- Reset, then Cond=1110, RegW=1, InstrValid=1 -> RegWrite=1, Flags=0000. Cond=0000 -> RegWrite=0.
- SUBS-style ALUFlags=0100, FlagW=11, Cond=AL at cycle t. Then Cond=EQ, PCS=1 at t+1 -> Flags=0100 after the t edge, and PCSrc=1 at t+1 (not at t).
- ADDS with Cond=NE while Z=1, FlagW=11, ALUFlags=1001 -> CondEx=0, Flags stays 0100, and MemWrite=RegWrite=0.
- FlagW=10, ALUFlags=1111 starting from Flags=0010 -> Flags=1110, with C,V preserved.
- CMP: NoWrite=1, RegW=1, FlagW=11, Cond=AL -> RegWrite=0, and Flags are updated.
- With CU_SQUASH_CNT_EN and CNT_W=2, five consecutive valid Cond=1111 instructions -> SquashCount sequence 1,2,3,3,3. Asserting rst_n=0 mid-sequence gives immediate 0.
